// File: rtl/ring_freq_meter.sv
// ring_freq_meter
// Gated frequency counter for an on-chip ring oscillator. A start request
// opens a gate window of 2^N clk cycles (N = gate_len clamped to GATE_W).
// During the window the meter counts synchronised rising edges of osc_in.
// The result is then published on count, together with a one-cycle valid strobe.
//
// Ports:
//   clk        reference clock
//   rst        asynchronous, active-high reset
//   osc_in     asynchronous oscillator signal being measured
//   start      level; begins a measurement when sampled in IDLE
//   stop       level; aborts ARM/GATE without producing a result
//   continuous 1 = re-arm automatically after each result
//   gate_len   log2 of the gate window, latched on start / re-arm
//   count      last completed measurement
//   valid      one-cycle strobe when count updates
//   busy       high while in ARM, GATE or DONE
//   overflow   accumulator saturated during the last completed window
//
// GATE_W must not exceed 31 because gate_len is 5 bits wide.

module ring_freq_meter #(
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             osc_in,
   input  logic             start,
   input  logic             stop,
   input  logic             continuous,
   input  logic [4:0]       gate_len,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             busy,
   output logic             overflow
);

   localparam int         ARM_W    = $clog2(SYNC_STAGES + 1);
   localparam int         TMR_W    = (GATE_W > ARM_W) ? GATE_W : ARM_W;
   localparam logic [4:0] GATE_MAX = 5'(GATE_W);

   typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rise;
   logic [TMR_W-1:0]       timer_q, timer_d, gate_last;
   logic [4:0]             n_q, n_d, n_clamped;
   logic [CNT_W-1:0]       acc_q, acc_d, acc_step;
   logic                   flag_q, flag_d, flag_step;
   logic [CNT_W-1:0]       count_d;
   logic                   valid_d, busy_d, overflow_d;

   // osc_in synchroniser plus one history flop for rising-edge detection.
   // This path runs in every state, so the history is already valid after ARM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign n_clamped = (gate_len > GATE_MAX) ? GATE_MAX : gate_len;

   // Terminal timer value for the gate window: the low N bits set (2^N - 1).
   always_comb begin
      gate_last = '0;
      for (int i = 0; i < TMR_W; i++) begin
         gate_last[i] = (i < int'(n_q));
      end
   end

   // Saturating accumulator step. At all-ones the value holds and the
   // window's overflow flag is set instead.
   always_comb begin
      acc_step  = acc_q;
      flag_step = flag_q;
      if (rise) begin
         if (&acc_q) begin
            flag_step = 1'b1;
         end else begin
            acc_step = acc_q + CNT_W'(1);
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + TMR_W'(1);
      n_d        = n_q;
      acc_d      = acc_q;
      flag_d     = flag_q;
      count_d    = count;
      overflow_d = overflow;
      valid_d    = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (start && !stop) begin
               state_d = ARM;
               n_d     = n_clamped;
               acc_d   = '0;
               flag_d  = 1'b0;
            end
         end
         ARM: begin
            if (stop) begin
               state_d = IDLE;
            end else if (timer_q == TMR_W'(SYNC_STAGES)) begin
               state_d = GATE;
               timer_d = '0;
            end
         end
         GATE: begin
            acc_d  = acc_step;
            flag_d = flag_step;
            if (stop) begin
               state_d = IDLE;
            end else if (timer_q == gate_last) begin
               // The step from the final gate cycle goes straight into the
               // published result, so a rise in that cycle is included.
               state_d    = DONE;
               count_d    = acc_step;
               overflow_d = flag_step;
               valid_d    = 1'b1;
            end
         end
         DONE: begin
            timer_d = '0;
            if (continuous) begin
               state_d = ARM;
               n_d     = n_clamped;
               acc_d   = '0;
               flag_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         n_q      <= '0;
         acc_q    <= '0;
         flag_q   <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
         valid    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         n_q      <= n_d;
         acc_q    <= acc_d;
         flag_q   <= flag_d;
         count    <= count_d;
         overflow <= overflow_d;
         valid    <= valid_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter
// Self-checking bench for ring_freq_meter. It uses reduced widths
// (CNT_W=8, GATE_W=12) so that saturation and gate_len clamping can be
// reached in a short run. Expected results come either from a constant
// vector table or from a reference model. The model counts rising
// transitions in the per-cycle osc_in samples. Each sample is seen by the
// edge counter SYNC cycles after it is captured.

module tb_ring_freq_meter;

   localparam int CNT_W  = 8;
   localparam int GATE_W = 12;
   localparam int SYNC   = 2;
   localparam int MAXC   = (1 << CNT_W) - 1;
   localparam int NVEC   = 7;

   logic             clk;
   logic             rst;
   logic             osc_in;
   logic             start;
   logic             stop;
   logic             continuous;
   logic [4:0]       gate_len;
   logic [CNT_W-1:0] count;
   logic             valid;
   logic             busy;
   logic             overflow;

   int tests;
   int fails;

   // Oscillator control: 0 = manual level, 1 = square wave, 2 = random bits
   int   osc_mode;
   int   osc_period;
   int   osc_phase = 0;
   logic osc_manual;

   // Per-edge capture of osc_in, plus a log of every valid pulse
   int cyc = 0;
   bit samp [0:65535];
   int valid_cyc [$];
   int valid_cnt [$];

   typedef struct {
      int gl;
      int period;
      int exp_count;
      int exp_ovf;
   } vec_t;

   vec_t vecs [NVEC];

   ring_freq_meter #(
      .CNT_W       (CNT_W),
      .GATE_W      (GATE_W),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .osc_in     (osc_in),
      .start      (start),
      .stop       (stop),
      .continuous (continuous),
      .gate_len   (gate_len),
      .count      (count),
      .valid      (valid),
      .busy       (busy),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // osc_in changes 2 time units after each rising edge.
   // It is therefore stable whenever the DUT samples it.
   always @(posedge clk) begin
      #2;
      case (osc_mode)
         1: begin
            osc_phase = (osc_phase + 1) % osc_period;
            osc_in    = (osc_phase < osc_period / 2);
         end
         2: osc_in = 1'($urandom_range(0, 1));
         default: osc_in = osc_manual;
      endcase
   end

   always @(posedge clk) begin
      if (cyc < 65536) samp[cyc] = osc_in;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (valid) begin
         valid_cyc.push_back(cyc);
         valid_cnt.push_back(int'(count));
      end
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic s, input logic sp, input logic c, input int gl);
      start      = s;
      stop       = sp;
      continuous = c;
      gate_len   = 5'(gl);
   endtask

   task automatic checkOutput(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference model for one window. The first ARM cycle follows edge e0.
   // The gate covers w cycles after the SYNC+1 flush cycles.
   task automatic modelWindow(input int e0, input int w, output int mc, output int mo);
      int rises = 0;
      for (int k = e0 + SYNC + 1; k <= e0 + SYNC + w; k++) begin
         if (samp[k - SYNC + 1] && !samp[k - SYNC]) rises++;
      end
      mc = (rises > MAXC) ? MAXC : rises;
      mo = (rises > MAXC) ? 1 : 0;
   endtask

   // One single-shot measurement. This task checks the pulse count, the
   // latency and that busy drops. It returns the model's expected result.
   task automatic runMeasure(input int gl, input string name, output int mc, output int mo);
      int e0, n, w;
      valid_cyc.delete();
      valid_cnt.delete();
      @(negedge clk);
      applyStimulus(1, 0, 0, gl);
      e0 = cyc;
      @(negedge clk);
      applyStimulus(0, 0, 0, gl);
      n = (gl > GATE_W) ? GATE_W : gl;
      w = 1 << n;
      repeat (SYNC + 3 + w) @(negedge clk);
      checkOutput({name, " valid pulses"}, valid_cyc.size(), 1);
      if (valid_cyc.size() > 0)
         checkOutput({name, " latency"}, valid_cyc[0] - 1 - e0, SYNC + 1 + w);
      checkOutput({name, " busy after"}, int'(busy), 0);
      modelWindow(e0, w, mc, mo);
   endtask

   initial begin
      int mc, mo, e0;
      int exp_cyc [4];

      tests = 0;
      fails = 0;
      vecs[0] = '{6, 8, 8, 0};
      vecs[1] = '{9, 2, 255, 1};
      vecs[2] = '{8, 2, 128, 0};
      vecs[3] = '{6, 8, 8, 0};
      vecs[4] = '{4, 4, 4, 0};
      vecs[5] = '{31, 32, 128, 0};
      vecs[6] = '{3, 2, 4, 0};

      rst        = 1'b1;
      osc_mode   = 0;
      osc_manual = 1'b0;
      osc_period = 8;
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("reset count", int'(count), 0);
      checkOutput("reset valid", int'(valid), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset overflow", int'(overflow), 0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("idle busy", int'(busy), 0);

      // Vector table: square waves whose edge counts are exact
      for (int i = 0; i < NVEC; i++) begin
         osc_mode   = 1;
         osc_period = vecs[i].period;
         repeat (3) @(negedge clk);
         runMeasure(vecs[i].gl, $sformatf("vec%0d", i), mc, mo);
         checkOutput($sformatf("vec%0d count", i), int'(count), vecs[i].exp_count);
         checkOutput($sformatf("vec%0d overflow", i), int'(overflow), vecs[i].exp_ovf);
      end

      // gate_len=0 with a rise inside the single gate cycle
      osc_mode   = 0;
      osc_manual = 1'b0;
      repeat (5) @(negedge clk);
      valid_cyc.delete();
      valid_cnt.delete();
      applyStimulus(1, 0, 0, 0);
      e0 = cyc;
      @(negedge clk);
      applyStimulus(0, 0, 0, 0);
      osc_manual = 1'b1;
      repeat (7) @(negedge clk);
      checkOutput("gl0 in pulses", valid_cyc.size(), 1);
      checkOutput("gl0 in count", int'(count), 1);

      // gate_len=0 with the rise one cycle after the window
      osc_manual = 1'b0;
      repeat (5) @(negedge clk);
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      osc_manual = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("gl0 late count", int'(count), 0);

      // Saturated result first, so the following aborts must preserve it
      osc_mode   = 1;
      osc_period = 2;
      runMeasure(9, "pre-stop", mc, mo);
      checkOutput("pre-stop count", int'(count), 255);
      checkOutput("pre-stop overflow", int'(overflow), 1);

      // stop at gate cycle 100 of a 1024-cycle window
      osc_period = 8;
      valid_cyc.delete();
      valid_cnt.delete();
      @(negedge clk);
      applyStimulus(1, 0, 0, 10);
      e0 = cyc;
      @(negedge clk);
      applyStimulus(0, 0, 0, 10);
      repeat (e0 + 104 - cyc) @(negedge clk);
      checkOutput("stop busy before", int'(busy), 1);
      applyStimulus(0, 1, 0, 10);
      @(negedge clk);
      checkOutput("stop busy next", int'(busy), 0);
      applyStimulus(0, 0, 0, 10);
      repeat (1100) @(negedge clk);
      checkOutput("stop no valid", valid_cyc.size(), 0);
      checkOutput("stop count kept", int'(count), 255);
      checkOutput("stop overflow kept", int'(overflow), 1);

      // stop during ARM
      applyStimulus(1, 0, 0, 3);
      @(negedge clk);
      applyStimulus(0, 1, 0, 3);
      @(negedge clk);
      applyStimulus(0, 0, 0, 3);
      checkOutput("arm stop busy", int'(busy), 0);
      repeat (30) @(negedge clk);
      checkOutput("arm stop no valid", valid_cyc.size(), 0);

      // stop has priority over start in IDLE
      applyStimulus(1, 1, 0, 4);
      repeat (5) @(negedge clk);
      checkOutput("stop prio busy", int'(busy), 0);
      applyStimulus(0, 0, 0, 4);
      repeat (30) @(negedge clk);
      checkOutput("stop prio no valid", valid_cyc.size(), 0);

      // Reset in the middle of GATE
      @(negedge clk);
      applyStimulus(1, 0, 0, 6);
      e0 = cyc;
      @(negedge clk);
      applyStimulus(0, 0, 0, 6);
      repeat (e0 + 30 - cyc) @(negedge clk);
      checkOutput("rst busy before", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst mid count", int'(count), 0);
      checkOutput("rst mid valid", int'(valid), 0);
      checkOutput("rst mid busy", int'(busy), 0);
      checkOutput("rst mid overflow", int'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("rst no valid", valid_cyc.size(), 0);

      // Continuous mode: stop in DONE is ignored, and dropping continuous
      // mid-window yields one more result
      osc_period = 4;
      valid_cyc.delete();
      valid_cnt.delete();
      @(negedge clk);
      applyStimulus(1, 0, 1, 4);
      e0 = cyc;
      @(negedge clk);
      applyStimulus(0, 0, 1, 4);
      repeat (e0 + 40 - cyc) @(negedge clk);
      applyStimulus(0, 1, 1, 4);
      @(negedge clk);
      applyStimulus(0, 0, 1, 4);
      repeat (e0 + 70 - cyc) @(negedge clk);
      checkOutput("cont busy mid", int'(busy), 1);
      applyStimulus(0, 0, 0, 4);
      repeat (e0 + 90 - cyc) @(negedge clk);
      checkOutput("cont busy end", int'(busy), 0);
      checkOutput("cont pulses", valid_cyc.size(), 4);
      for (int i = 0; i < 4; i++) exp_cyc[i] = e0 + 20 * (i + 1);
      for (int i = 0; i < 4; i++) begin
         if (i < valid_cyc.size()) begin
            checkOutput($sformatf("cont pulse%0d cycle", i), valid_cyc[i] - e0, exp_cyc[i] - e0);
            checkOutput($sformatf("cont pulse%0d count", i), valid_cnt[i], 4);
         end
      end

      // start held high with continuous=0: restart after one IDLE cycle
      valid_cyc.delete();
      valid_cnt.delete();
      @(negedge clk);
      applyStimulus(1, 0, 0, 2);
      e0 = cyc;
      repeat (20) @(negedge clk);
      applyStimulus(0, 0, 0, 2);
      repeat (e0 + 40 - cyc) @(negedge clk);
      checkOutput("held pulses", valid_cyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < valid_cyc.size()) begin
            checkOutput($sformatf("held pulse%0d cycle", i), valid_cyc[i] - e0, 8 + 9 * i);
            checkOutput($sformatf("held pulse%0d count", i), valid_cnt[i], 1);
         end
      end

      // start pulses and gate_len changes during ARM/GATE have no effect
      valid_cyc.delete();
      valid_cnt.delete();
      @(negedge clk);
      applyStimulus(1, 0, 0, 4);
      e0 = cyc;
      @(negedge clk);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      applyStimulus(1, 0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0);
      repeat (e0 + 10 - cyc) @(negedge clk);
      applyStimulus(1, 0, 0, 7);
      @(negedge clk);
      applyStimulus(0, 0, 0, 7);
      repeat (e0 + 45 - cyc) @(negedge clk);
      checkOutput("pulse pulses", valid_cyc.size(), 1);
      if (valid_cyc.size() > 0)
         checkOutput("pulse cycle", valid_cyc[0] - e0, 20);
      checkOutput("pulse count", int'(count), 4);

      // Randomised oscillator against the reference model
      for (int i = 0; i < 10; i++) begin
         osc_mode   = $urandom_range(1, 2);
         osc_period = $urandom_range(2, 9);
         repeat ($urandom_range(1, 7)) @(negedge clk);
         runMeasure($urandom_range(0, 7), $sformatf("rand%0d", i), mc, mo);
         checkOutput($sformatf("rand%0d count", i), int'(count), mc);
         checkOutput($sformatf("rand%0d overflow", i), int'(overflow), mo);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
